// File: rtl/sevenseg_scan_mux.sv
// N-digit time-multiplexed 7-segment driver with blanking gaps, PWM dimming,
// leading-zero suppression and frame-latched inputs. Segments/anodes active-low.
module sevenseg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 125,
  parameter int BLANK_TICKS = 4,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W = $clog2(DIGIT_TICKS + BLANK_TICKS + 1);
  localparam logic [IDX_W-1:0]  MSD        = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] LAST_ON    = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] LAST_BLANK = TICK_W'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [TICK_W-1:0]       tick, tick_n;
  logic [BRIGHT_W-1:0]     pwm, pwm_n;

  logic [4*NUM_DIGITS-1:0] dig_l, dig_n;
  logic [NUM_DIGITS-1:0]   dp_l, dp_n;
  logic [NUM_DIGITS-1:0]   mask_l, mask_n;
  logic                    lz_l, lz_n;
  logic [BRIGHT_W-1:0]     bri_l, bri_n;

  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    fs_n;
  logic                    latch;
  logic                    suppressed;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= MSD;
      tick        <= '0;
      pwm         <= '0;
      dig_l       <= '0;
      dp_l        <= '0;
      mask_l      <= '0;
      lz_l        <= 1'b0;
      bri_l       <= '0;
      seg         <= 8'hFF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      tick        <= tick_n;
      pwm         <= pwm_n;
      dig_l       <= dig_n;
      dp_l        <= dp_n;
      mask_l      <= mask_n;
      lz_l        <= lz_n;
      bri_l       <= bri_n;
      seg         <= seg_n;
      an          <= an_n;
      frame_start <= fs_n;
    end
  end

  // Sequencing: IDLE -> (BLANK -> ON) per digit, MSD first; relatch after digit 0.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tick_n  = tick;
    pwm_n   = pwm;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          latch   = 1'b1;
          state_n = BLANK;
          idx_n   = MSD;
          tick_n  = '0;
          pwm_n   = '0;
        end
      end
      BLANK: begin
        if (!en) begin
          state_n = IDLE;
          idx_n   = MSD;
          tick_n  = '0;
          pwm_n   = '0;
        end else if (tick == LAST_BLANK) begin
          state_n = ON;
          tick_n  = '0;
          pwm_n   = '0;
        end else begin
          tick_n = tick + TICK_W'(1);
        end
      end
      ON: begin
        if (!en) begin
          state_n = IDLE;
          idx_n   = MSD;
          tick_n  = '0;
          pwm_n   = '0;
        end else begin
          pwm_n = pwm + BRIGHT_W'(1);
          if (tick == LAST_ON) begin
            tick_n  = '0;
            state_n = BLANK;
            if (idx == '0) begin
              latch = 1'b1;
              idx_n = MSD;
            end else begin
              idx_n = idx - IDX_W'(1);
            end
          end else begin
            tick_n = tick + TICK_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = MSD;
        tick_n  = '0;
        pwm_n   = '0;
      end
    endcase
  end

  // Frame registers and registered outputs are derived from the next-cycle state,
  // so seg/an line up exactly with the state they belong to.
  always_comb begin
    dig_n  = latch ? digits      : dig_l;
    dp_n   = latch ? dp          : dp_l;
    mask_n = latch ? blank_mask  : mask_l;
    lz_n   = latch ? lz_suppress : lz_l;
    bri_n  = latch ? brightness  : bri_l;
    fs_n   = latch;
    seg_n  = 8'hFF;
    an_n   = '1;

    suppressed = lz_n && (idx_n != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_n) && dig_n[4*i +: 4] != 4'd0) suppressed = 1'b0;
    end

    if (state_n == ON && !mask_n[idx_n]) begin
      if (pwm_n < bri_n) an_n[idx_n] = 1'b0;
      seg_n = {~dp_n[idx_n], suppressed ? 7'h7F : hex7(dig_n[4*idx_n +: 4])};
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Scoreboard bench for sevenseg_scan_mux: a frame model pushes expected
// {frame_start, an, seg} per cycle; each cycle pops and compares.
module tb_sevenseg_scan_mux;

  localparam int ND = 4;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam int BW = 2;
  localparam int FRAME = ND * (BT + DT);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    blank_mask = '0;
  logic          lz_suppress = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_start;

  int checks = 0;
  int failures = 0;
  logic [12:0] sb[$];

  sevenseg_scan_mux #(
    .NUM_DIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress), .brightness(brightness),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed fs/an/seg=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dpv,
                                input logic [3:0] m, input logic lz, input logic [BW-1:0] b);
    digits      = d;
    dp          = dpv;
    blank_mask  = m;
    lz_suppress = lz;
    brightness  = b;
  endtask

  // Expected output of one full frame built from the inputs the bench is driving now.
  task automatic push_frame();
    for (int d = ND - 1; d >= 0; d--) begin
      logic [7:0] s;
      logic [3:0] a;
      logic       supp;
      supp = lz_suppress && (d > 0);
      for (int k = d; k < ND; k++) if (digits[4*k +: 4] != 4'd0) supp = 1'b0;
      if (blank_mask[d]) s = 8'hFF;
      else s = {~dp[d], supp ? 7'h7F : hex7(digits[4*d +: 4])};
      for (int c = 0; c < BT; c++) sb.push_back({(d == ND - 1 && c == 0), 4'hF, 8'hFF});
      for (int c = 0; c < DT; c++) begin
        a = 4'hF;
        if (!blank_mask[d] && (c % (2**BW)) < int'(brightness)) a[d] = 1'b0;
        sb.push_back({1'b0, a, s});
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s scoreboard empty observed=%h required=entry", tag, {frame_start, an, seg});
    end else begin
      check_output(tag, {frame_start, an, seg}, sb.pop_front());
    end
  endtask

  task automatic run_frame(input string tag, input int change_at, input logic [15:0] new_digits);
    push_frame();
    for (int c = 0; c < FRAME; c++) begin
      step(tag);
      if (c == change_at) digits = new_digits;
    end
  endtask

  // At most one anode may be low in any cycle.
  always @(negedge clk) begin
    checks++;
    assert ($countones(~an) <= 1) else begin
      failures++;
      $error("[TB] FAIL anode_onehot observed an=%b required at most one zero", an);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", {frame_start, an, seg}, {1'b0, 4'hF, 8'hFF});
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("idle_dark", {frame_start, an, seg}, {1'b0, 4'hF, 8'hFF});

    apply_stimulus(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    en = 1'b1;
    run_frame("basic", -1, 16'h0);
    run_frame("basic2", -1, 16'h0);

    apply_stimulus(16'h0070, 4'b0100, 4'h0, 1'b1, 2'd3);
    run_frame("lz_on", -1, 16'h0);
    lz_suppress = 1'b0;
    run_frame("lz_off", -1, 16'h0);

    brightness = 2'd0;
    run_frame("bright0", -1, 16'h0);
    brightness = 2'd1;
    run_frame("bright1", -1, 16'h0);

    apply_stimulus(16'h12AF, 4'hF, 4'b0010, 1'b0, 2'd3);
    run_frame("mask", -1, 16'h0);

    apply_stimulus(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
    run_frame("tear", 12, 16'h2222);
    run_frame("tear_next", -1, 16'h0);

    push_frame();
    for (int c = 0; c < 25; c++) step("pre_drop");
    en = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) sb.push_back({1'b0, 4'hF, 8'hFF});
    for (int c = 0; c < 3; c++) step("en_drop");

    en = 1'b1;
    run_frame("resume", -1, 16'h0);

    push_frame();
    for (int c = 0; c < 14; c++) step("pre_rst");
    #2 rst = 1'b0;
    #1;
    check_output("async_rst", {frame_start, an, seg}, {1'b0, 4'hF, 8'hFF});
    sb.delete();
    en = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_hold", {frame_start, an, seg}, {1'b0, 4'hF, 8'hFF});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_idle", {frame_start, an, seg}, {1'b0, 4'hF, 8'hFF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Parametrised N-digit time-multiplexed 7-segment driver; successor to the fixed 4-digit scanner.
- Adds:
  - per-digit decimal point and blank mask
  - leading-zero suppression
  - inter-digit ghost blanking
  - PWM brightness
  - tear-free frame latching and a frame_start strobe
- Sits between display-value producers (counters, waveform status) and the board's active-low segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes (>=2).
- DIGIT_TICKS, 125, clk cycles per digit ON phase (>=1).
- BLANK_TICKS, 4, clk cycles all-anodes-off before each digit (>=1).
- BRIGHT_W, 4, brightness/PWM counter width (1..8).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i]; digit 0 = rightmost/LSD.
- dp  in  NUM_DIGITS  decimal point request per digit, 1=on.
- blank_mask  in  NUM_DIGITS  1=digit fully dark, including dp.
- lz_suppress  in  1  1=suppress leading zeros.
- brightness  in  BRIGHT_W  PWM level; 0=dark, 2^BRIGHT_W-1 = near-full.
- seg  out  8  active-low; seg[7]=dp, seg[6:0]=gfedcba.
- an  out  NUM_DIGITS  active-low anode; an[i] drives digit i.
- frame_start  out  1  one-cycle pulse when a new frame's inputs are latched.

Behaviour:
- Reset (rst=0, async):
  - seg=8'hFF, an=all 1s, frame_start=0.
  - state=IDLE; idx=NUM_DIGITS-1; tick and pwm counters 0.
  - Latched copies cleared to 0.
- All outputs are registered.
- States: IDLE, BLANK, ON.
- IDLE:
  - Outputs dark.
  - On a clk edge with en=1: latch digits, dp, blank_mask, lz_suppress and brightness into frame registers.
  - Same edge: frame_start<=1, idx<=NUM_DIGITS-1, state<=BLANK.
- BLANK:
  - an all 1s, seg=8'hFF for exactly BLANK_TICKS cycles, then go to ON with pwm=0.
- ON:
  - Lasts exactly DIGIT_TICKS cycles.
  - Each cycle: an[idx]=0 iff pwm<brightness_latched and digit idx is not masked; other anodes are 1.
  - seg = decoded pattern of digit idx.
  - pwm increments modulo 2^BRIGHT_W and restarts at 0 on each ON entry.
  - At end: if idx>0, idx<=idx-1 and go to BLANK.
  - If idx==0: relatch all inputs, pulse frame_start, idx<=NUM_DIGITS-1, go to BLANK.
- Scan order is MSD first (idx NUM_DIGITS-1 down to 0).
- Frame period = NUM_DIGITS*(BLANK_TICKS+DIGIT_TICKS) cycles.
- Inputs are sampled only at latch points; changes mid-frame never show until the next frame.
- Decode, seg[6:0] in hex:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- seg[7]=~dp_latched[idx].
- Leading-zero suppression: with lz latched=1, digit i>0 is suppressed iff all latched digits NUM_DIGITS-1..i equal 0.
  - A suppressed digit has seg[6:0]=7F; its dp is still shown.
  - Digit 0 is never suppressed.
- blank_mask[i]=1: an[i] stays 1 for the whole ON phase; seg=8'hFF.
- en=0 while in BLANK/ON: on the next edge go to IDLE, outputs dark, idx reset.
- en re-asserted: a full fresh frame starts from the MSD; there is no resume.
- Never more than one anode low in any cycle; never an anode low during BLANK.
- Reset asserted mid-frame: immediate dark outputs and IDLE state, independent of clk.

Test Plan (bench params NUM_DIGITS=4, DIGIT_TICKS=8, BLANK_TICKS=2, BRIGHT_W=2):
- Reset then en=1, digits=16'h12AF, dp=0, brightness=3:
  - frame_start pulses once every 40 cycles.
  - Per slot: 2 dark cycles, then 6 of 8 ON cycles with an low.
  - Order an=0111/1011/1101/1110.
  - seg=F9, A4, 88, 8E.
- digits=16'h0070, lz_suppress=1, dp=4'b0100, brightness=3:
  - digit3 shows seg=FF.
  - digit2 shows seg=7F (dp only).
  - digit1 shows F8; digit0 shows C0.
  - With lz_suppress=0, digit3 shows C0.
- brightness=0 -> an stays 1111 for an entire frame.
- brightness=1 -> an low for 2 of 8 ON cycles per digit (pwm=0 and pwm=4).
- blank_mask=4'b0010, dp=4'hF -> an[1] never low; other digits unaffected.
- Change digits from 16'h1111 to 16'h2222 mid-frame (during idx=2):
  - the rest of that frame still shows seg=F9;
  - the next frame shows A4 from its MSD.
- Drop en during ON of idx=1 -> next cycle an=1111, seg=FF.
- Re-raise en -> frame_start pulse, then scan restarts at an=0111 after 2 blank cycles.
- Assert rst low asynchronously mid-ON -> seg=FF, an=1111 before the next clk edge.
- Assertion throughout all scenarios: an never has two zeros in any cycle.
